// File: rtl/dtree_walk_engine_if.sv
// ============================================================================
// Module   : dtree_walk_engine_if
// Brief    : Config, feature-input and class-output bundle for the tree walker.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dtree_walk_engine_if #(
    parameter int N_FEAT  = 51,
    parameter int NODE_AW = 6,
    parameter int CLASS_W = 2
) ();
    localparam int FIDX_W  = $clog2(N_FEAT);
    localparam int ENTRY_W = 1 + FIDX_W + 2 * NODE_AW;

    logic                 cfg_we;
    logic [NODE_AW-1:0]   cfg_addr;
    logic [ENTRY_W-1:0]   cfg_wdata;
    logic                 cfg_nack;
    logic                 in_valid;
    logic                 in_ready;
    logic [N_FEAT-1:0]    in_feat;
    logic                 out_valid;
    logic                 out_ready;
    logic [CLASS_W-1:0]   out_class;
    logic                 out_err;
    logic [NODE_AW-1:0]   out_steps;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
        input  cfg_nack, in_ready, out_valid, out_class, out_err, out_steps
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
        output cfg_nack, in_ready, out_valid, out_class, out_err, out_steps
    );
endinterface

`default_nettype wire

// File: rtl/dtree_walk_engine.sv
// ============================================================================
// Module   : dtree_walk_engine
// Brief    : Sequential decision-tree classifier, one node evaluated per clock.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dtree_walk_engine #(
    parameter int N_FEAT    = 51,
    parameter int NODE_AW   = 6,
    parameter int CLASS_W   = 2,
    parameter int MAX_STEPS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dtree_walk_engine_if.slave   bus
);
    localparam int FIDX_W  = $clog2(N_FEAT);
    localparam int ENTRY_W = 1 + FIDX_W + 2 * NODE_AW;
    localparam int N_NODES = 2 ** NODE_AW;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_walk = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [NODE_AW-1:0]  c_max_steps = NODE_AW'(MAX_STEPS);
    localparam logic [FIDX_W:0]     c_n_feat    = (FIDX_W + 1)'(N_FEAT);

    logic [1:0]              state_q,  state_d;
    logic [N_FEAT-1:0]       feat_q,   feat_d;
    logic [NODE_AW-1:0]      node_q,   node_d;
    logic [NODE_AW-1:0]      steps_q,  steps_d;
    logic [CLASS_W-1:0]      class_q,  class_d;
    logic                    err_q,    err_d;
    logic                    nack_q,   nack_d;
    logic [N_NODES-1:0]      valid_q,  valid_d;
    logic [ENTRY_W-1:0]      tbl_q [N_NODES];

    logic [ENTRY_W-1:0]      w_entry;
    logic                    w_is_leaf;
    logic [FIDX_W-1:0]       w_fidx;
    logic [NODE_AW-1:0]      w_true;
    logic [NODE_AW-1:0]      w_false;
    logic                    w_node_ok;
    logic                    w_fidx_ok;
    logic [2**FIDX_W-1:0]    w_feat_pad;
    logic                    w_bit;
    logic [NODE_AW-1:0]      w_steps_inc;
    logic                    w_cfg_ok;

    // Table is only writable while idle so a walk always sees a frozen tree.
    assign w_cfg_ok    = bus.cfg_we && (state_q == c_idle);

    assign w_entry     = tbl_q[node_q];
    assign w_is_leaf   = w_entry[ENTRY_W-1];
    assign w_fidx      = w_entry[ENTRY_W-2 -: FIDX_W];
    assign w_true      = w_entry[2*NODE_AW-1 -: NODE_AW];
    assign w_false     = w_entry[NODE_AW-1:0];
    assign w_node_ok   = valid_q[node_q];
    assign w_fidx_ok   = ({1'b0, w_fidx} < c_n_feat);
    assign w_steps_inc = steps_q + NODE_AW'(1);

    // Pad the sample to the full index range so out-of-range indices stay in bounds.
    always_comb begin
        w_feat_pad                = '0;
        w_feat_pad[N_FEAT-1:0]    = feat_q;
    end
    assign w_bit = w_feat_pad[w_fidx];

    always_comb begin
        state_d = state_q;
        feat_d  = feat_q;
        node_d  = node_q;
        steps_d = steps_q;
        class_d = class_q;
        err_d   = err_q;
        valid_d = valid_q;
        nack_d  = bus.cfg_we && (state_q != c_idle);

        if (w_cfg_ok) begin
            valid_d[bus.cfg_addr] = 1'b1;
        end

        case (state_q)
            c_idle: begin
                if (bus.in_valid) begin
                    feat_d  = bus.in_feat;
                    node_d  = '0;
                    steps_d = '0;
                    state_d = c_walk;
                end
            end
            c_walk: begin
                steps_d = w_steps_inc;
                if (!w_node_ok || !w_fidx_ok) begin
                    err_d   = 1'b1;
                    class_d = '0;
                    state_d = c_done;
                end else if (w_is_leaf) begin
                    err_d   = 1'b0;
                    class_d = w_false[CLASS_W-1:0];
                    state_d = c_done;
                end else if (w_steps_inc == c_max_steps) begin
                    err_d   = 1'b1;
                    class_d = '0;
                    state_d = c_done;
                end else begin
                    node_d  = w_bit ? w_true : w_false;
                end
            end
            c_done: begin
                if (bus.out_ready) begin
                    state_d = c_idle;
                end
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_idle;
            feat_q  <= '0;
            node_q  <= '0;
            steps_q <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
            nack_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            feat_q  <= feat_d;
            node_q  <= node_d;
            steps_q <= steps_d;
            class_q <= class_d;
            err_q   <= err_d;
            nack_q  <= nack_d;
            valid_q <= valid_d;
        end
    end

    // Node storage carries no reset; the valid bits alone decide what is usable.
    always_ff @(posedge clk) begin
        if (w_cfg_ok) begin
            tbl_q[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    assign bus.in_ready  = (state_q == c_idle);
    assign bus.out_valid = (state_q == c_done);
    assign bus.out_class = class_q;
    assign bus.out_err   = err_q;
    assign bus.out_steps = steps_q;
    assign bus.cfg_nack  = nack_q;

endmodule

`default_nettype wire

// File: tb/tb_dtree_walk_engine.sv
// ============================================================================
// Module   : tb_dtree_walk_engine
// Brief    : Directed plus randomized bench against a table-walking reference.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dtree_walk_engine;
    localparam int N_FEAT    = 51;
    localparam int NODE_AW   = 6;
    localparam int CLASS_W   = 2;
    localparam int MAX_STEPS = 16;
    localparam int N_NODES   = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dtree_walk_engine_if #(.N_FEAT(N_FEAT), .NODE_AW(NODE_AW), .CLASS_W(CLASS_W)) bus ();

    dtree_walk_engine #(
        .N_FEAT(N_FEAT), .NODE_AW(NODE_AW), .CLASS_W(CLASS_W), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference: node table as plain field arrays plus a result countdown.
    bit m_vld  [N_NODES];
    bit m_leaf [N_NODES];
    int m_fidx [N_NODES];
    int m_tc   [N_NODES];
    int m_fc   [N_NODES];
    bit m_busy;
    int m_wait;
    int m_cls;
    bit m_err;
    int m_steps;
    bit m_nack;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_walk(input logic [N_FEAT-1:0] f,
                                       output int cls, output bit err, output int steps);
        int n;
        n = 0; cls = 0; err = 1'b0; steps = 0;
        for (int v = 1; v <= MAX_STEPS; v++) begin
            steps = v;
            if (!m_vld[n] || m_fidx[n] >= N_FEAT) begin err = 1'b1; return; end
            if (m_leaf[n]) begin cls = m_fc[n] % (1 << CLASS_W); return; end
            if (v == MAX_STEPS) begin err = 1'b1; return; end
            n = f[m_fidx[n]] ? m_tc[n] : m_fc[n];
        end
    endfunction

    initial begin
        int a;
        m_busy = 1'b0; m_wait = 0; m_cls = 0; m_err = 1'b0; m_steps = 0; m_nack = 1'b0;
        foreach (m_vld[i]) begin
            m_vld[i] = 1'b0; m_leaf[i] = 1'b0; m_fidx[i] = 0; m_tc[i] = 0; m_fc[i] = 0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 1'b0; m_wait = 0; m_nack = 1'b0;
                foreach (m_vld[i]) m_vld[i] = 1'b0;
            end else begin
                m_nack = bus.cfg_we && m_busy;
                if (!m_busy) begin
                    if (bus.cfg_we) begin
                        a = int'(bus.cfg_addr);
                        m_vld[a]  = 1'b1;
                        m_leaf[a] = bus.cfg_wdata[18];
                        m_fidx[a] = int'(bus.cfg_wdata[17:12]);
                        m_tc[a]   = int'(bus.cfg_wdata[11:6]);
                        m_fc[a]   = int'(bus.cfg_wdata[5:0]);
                    end
                    if (bus.in_valid) begin
                        model_walk(bus.in_feat, m_cls, m_err, m_steps);
                        m_busy = 1'b1;
                        m_wait = m_steps;
                    end
                end else if (m_wait > 0) begin
                    m_wait--;
                end else if (bus.out_ready) begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("in_ready",  int'(bus.in_ready),  int'(!m_busy));
                check("out_valid", int'(bus.out_valid), int'(m_busy && m_wait == 0));
                check("cfg_nack",  int'(bus.cfg_nack),  int'(m_nack));
                if (m_busy && m_wait == 0 && bus.out_valid) begin
                    check("out_class", int'(bus.out_class), m_cls);
                    check("out_err",   int'(bus.out_err),   int'(m_err));
                    check("out_steps", int'(bus.out_steps), m_steps);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int a, input bit leaf, input int fidx, input int tc, input int fc);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = NODE_AW'(a);
        bus.cfg_wdata = {leaf, 6'(fidx), 6'(tc), 6'(fc)};
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    function automatic logic [N_FEAT-1:0] rnd_feat();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[N_FEAT-1:0];
    endfunction

    task automatic send(input logic [N_FEAT-1:0] f);
        bus.in_valid = 1'b1;
        bus.in_feat  = f;
        for (int i = 0; i < 200 && !bus.in_ready; i++) tick();
        if (!bus.in_ready) check("send_timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(output int cls, output int err, output int steps, output int lat);
        bus.out_ready = 1'b1;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) check("result_timeout", 0, 1);
        cls   = int'(bus.out_class);
        err   = int'(bus.out_err);
        steps = int'(bus.out_steps);
        tick();
    endtask

    task automatic gen_random_entry(output bit leaf, output int fidx, output int tc, output int fc);
        leaf = ($urandom_range(0, 9) < 4);
        fidx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(51, 63)) : int'($urandom_range(0, 50));
        tc   = int'($urandom_range(0, 31));
        fc   = int'($urandom_range(0, 31));
    endtask

    int cls, err, steps, lat;
    bit lf;
    int fi, tcv, fcv;
    logic [N_FEAT-1:0] f;
    int pb50 [4] = '{1, 0, 1, 0};
    int pb48 [4] = '{1, 0, 0, 1};
    int pb37 [4] = '{1, 0, 1, 0};
    int pcls [4] = '{0, 3, 2, 1};

    initial begin
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.in_valid = 1'b0; bus.in_feat = '0; bus.out_ready = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        check("rst_in_ready",  int'(bus.in_ready),  1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_class", int'(bus.out_class), 0);
        check("rst_out_err",   int'(bus.out_err),   0);
        check("rst_out_steps", int'(bus.out_steps), 0);
        check("rst_cfg_nack",  int'(bus.cfg_nack),  0);

        // Root leaf of class 2.
        cfg_write(0, 1'b1, 0, 0, 2);
        send(rnd_feat());
        collect(cls, err, steps, lat);
        check("root_cls", cls, 2);
        check("root_err", err, 0);
        check("root_steps", steps, 1);
        check("root_lat", lat, 2);

        // Three-level tree on bits 50 / 48 / 37, leaves at 7..14.
        cfg_write(0, 1'b0, 50, 1, 2);
        cfg_write(1, 1'b0, 48, 3, 4);
        cfg_write(2, 1'b0, 48, 5, 6);
        for (int k = 3; k <= 6; k++) cfg_write(k, 1'b0, 37, 7 + 2 * (k - 3), 8 + 2 * (k - 3));
        for (int a = 7; a <= 14; a++) cfg_write(a, 1'b1, 0, 0, (a - 7) % 4);
        for (int p = 0; p < 4; p++) begin
            f = rnd_feat();
            f[50] = pb50[p][0]; f[48] = pb48[p][0]; f[37] = pb37[p][0];
            send(f);
            collect(cls, err, steps, lat);
            check("tree_cls", cls, pcls[p]);
            check("tree_err", err, 0);
            check("tree_steps", steps, 4);
            check("tree_lat", lat, 5);
        end

        // Backpressure: result must sit still while a second sample is offered.
        f = '0; f[50] = 1'b1; f[48] = 1'b1; f[37] = 1'b1;
        bus.out_ready = 1'b0;
        send(f);
        bus.in_valid = 1'b1;
        bus.in_feat  = ~f;
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", int'(bus.out_valid), 1);
            check("bp_class", int'(bus.out_class), 0);
            check("bp_ready", int'(bus.in_ready), 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        // Config write while walking is refused and the old leaf survives.
        f = '0;
        send(f);
        cfg_write(14, 1'b1, 0, 0, 1);
        check("nack_pulse", int'(bus.cfg_nack), 1);
        collect(cls, err, steps, lat);
        check("nack_cls", cls, 3);
        send(f);
        collect(cls, err, steps, lat);
        check("nack_rerun_cls", cls, 3);

        // Error traversals.
        do_reset();
        cfg_write(0, 1'b0, 0, 10, 10);
        send(rnd_feat());
        collect(cls, err, steps, lat);
        check("unwritten_err", err, 1);
        check("unwritten_cls", cls, 0);
        check("unwritten_steps", steps, 2);
        cfg_write(0, 1'b0, 60, 1, 1);
        send(rnd_feat());
        collect(cls, err, steps, lat);
        check("fidx_err", err, 1);
        check("fidx_steps", steps, 1);
        cfg_write(0, 1'b0, 5, 0, 0);
        send(rnd_feat());
        collect(cls, err, steps, lat);
        check("loop_err", err, 1);
        check("loop_cls", cls, 0);
        check("loop_steps", steps, MAX_STEPS);
        check("loop_lat", lat, MAX_STEPS + 1);

        // Reset in the middle of a walk.
        send(rnd_feat());
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        for (int i = 0; i < 20; i++) tick();
        send(rnd_feat());
        collect(cls, err, steps, lat);
        check("abort_next_err", err, 1);
        check("abort_next_steps", steps, 1);

        // Randomized traffic with config writes interleaved at any time.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            gen_random_entry(lf, fi, tcv, fcv);
            cfg_write(int'($urandom_range(0, 31)), lf, fi, tcv, fcv);
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 7) == 0) begin
                gen_random_entry(lf, fi, tcv, fcv);
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = NODE_AW'($urandom_range(0, 31));
                bus.cfg_wdata = {lf, 6'(fi), 6'(tcv), 6'(fcv)};
            end else begin
                bus.cfg_we = 1'b0;
            end
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.in_feat   = rnd_feat();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.cfg_we    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
